pump_dose_controller: RTL and testbench

//  Timed-dose pump relay controller for manual mode. N selectable dose presets, each a runtime-loaded

---
 rtl/pump_pkg.sv | 18 +
 rtl/pump_dose_controller_btn_sync_edge.sv | 76 +++++++
 rtl/pump_dose_controller.sv | 190 +++++++++++++++++++
 tb/tb_pump_dose_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// -----------------------------------------------------------------------------
// pump_pkg
// Shared definitions for the manual-mode pump dose controller.
//   state_t          : controller state encoding (ST_IDLE, ST_PUMP, ST_PAUSE)
//   MODE_CODE_*      : system mode codes driven on the controller's mode input
// -----------------------------------------------------------------------------
package pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUMP  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_CODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_CODE_AUTO   = 2'b01;

endpackage

// File: rtl/pump_dose_controller_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings one active-low push button into the clock domain and emits a
// single-cycle press event on the high-to-low transition.
// Optional macro DOSE_DEBOUNCE_EN inserts a counter debouncer after the
// synchroniser (level accepted after DEB_TICKS equal samples).
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (all stages reset to released = 1)
//   pin    in  raw button level
//   press  out one-cycle press event
// -----------------------------------------------------------------------------
module btn_sync_edge
`ifdef DOSE_DEBOUNCE_EN
  #(parameter int DEB_TICKS = 20000)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic press
);

  logic meta_q;
  logic sync_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
    end
  end

`ifdef DOSE_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_TICKS + 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any bounce back to the accepted level restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b1;
    end else if (sync_q == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
      deb_cnt   <= '0;
      deb_level <= sync_q;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign level = deb_level;
`else
  assign level = sync_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign press = prev_q & ~level;

endmodule

// File: rtl/pump_dose_controller.sv
// -----------------------------------------------------------------------------
// pump_dose_controller
// Manual-mode timed-dose pump relay controller. Each of N_PRESET buttons
// starts a dose whose length in clock ticks is loaded from cfg_ticks. The dose
// can be paused/resumed, and is aborted by estop or by leaving manual mode.
// Optional macro DOSE_DEBOUNCE_EN adds a debouncer to every button
// (parameter DEB_TICKS only exists in that build).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   mode         system mode; block is live only when mode == MODE_MANUAL
//   btn          dose buttons (press = falling edge after sync)
//   btn_pause    pause/resume toggle button
//   estop        emergency stop level, active-high
//   cfg_ticks    preset i tick count at [i*CNT_W +: CNT_W]
//   relay        pump relay drive (high in PUMP)
//   busy         high in PUMP or PAUSE
//   paused       high in PAUSE
//   active_sel   index of running preset, holds last value when idle
//   remaining    ticks left in the current dose, 0 when idle
//   done         1-cycle pulse, dose completed
//   aborted      1-cycle pulse, dose ended by estop or mode change
//   err          1-cycle pulse, press on a preset loaded with 0
//   state_dbg    current controller state
//
// Handshake: none; every press is a single-cycle event, every result is a
// single-cycle pulse registered on the edge that leaves the dose.
// -----------------------------------------------------------------------------
module pump_dose_controller
  import pump_pkg::*;
#(
  parameter int               N_PRESET    = 4,
  parameter int               CNT_W       = 32,
  parameter int               MODE_W      = 2,
  parameter logic [MODE_W-1:0] MODE_MANUAL = MODE_W'(MODE_CODE_MANUAL),
  localparam int              SEL_W       = (N_PRESET > 1) ? $clog2(N_PRESET) : 1
`ifdef DOSE_DEBOUNCE_EN
  , parameter int             DEB_TICKS   = 20000
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MODE_W-1:0]         mode,
  input  logic [N_PRESET-1:0]       btn,
  input  logic                      btn_pause,
  input  logic                      estop,
  input  logic [N_PRESET*CNT_W-1:0] cfg_ticks,
  output logic                      relay,
  output logic                      busy,
  output logic                      paused,
  output logic [SEL_W-1:0]          active_sel,
  output logic [CNT_W-1:0]          remaining,
  output logic                      done,
  output logic                      aborted,
  output logic                      err,
  output state_t                    state_dbg
);

  logic [N_PRESET-1:0] dose_ev;
  logic                pause_ev;

  for (genvar g = 0; g < N_PRESET; g++) begin : g_btn
    btn_sync_edge
`ifdef DOSE_DEBOUNCE_EN
      #(.DEB_TICKS(DEB_TICKS))
`endif
      u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (btn[g]),
        .press (dose_ev[g])
      );
  end

  btn_sync_edge
`ifdef DOSE_DEBOUNCE_EN
    #(.DEB_TICKS(DEB_TICKS))
`endif
    u_pause (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (btn_pause),
      .press (pause_ev)
    );

  state_t           state, state_n;
  logic [CNT_W-1:0] rem_n;
  logic [SEL_W-1:0] sel_n;
  logic             done_n, aborted_n, err_n;

  logic             enable;
  logic             pick_hit;
  logic [SEL_W-1:0] pick_idx;
  logic [CNT_W-1:0] pick_ticks;

  assign enable = (mode == MODE_MANUAL) && !estop;

  // Lowest pressed index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    pick_hit   = 1'b0;
    pick_idx   = '0;
    pick_ticks = '0;
    for (int i = N_PRESET - 1; i >= 0; i--) begin
      if (dose_ev[i]) begin
        pick_hit   = 1'b1;
        pick_idx   = SEL_W'(i);
        pick_ticks = cfg_ticks[i*CNT_W +: CNT_W];
      end
    end
  end

  // Order of tests inside each state encodes abort > completion > pause > start.
  always_comb begin
    state_n   = state;
    rem_n     = remaining;
    sel_n     = active_sel;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        rem_n = '0;
        if (enable && pick_hit) begin
          if (pick_ticks != '0) begin
            state_n = ST_PUMP;
            rem_n   = pick_ticks;
            sel_n   = pick_idx;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_PUMP: begin
        if (!enable) begin
          state_n   = ST_IDLE;
          rem_n     = '0;
          aborted_n = 1'b1;
        end else if (remaining <= CNT_W'(1)) begin
          // <= rather than == keeps the counter from ever wrapping.
          state_n = ST_IDLE;
          rem_n   = '0;
          done_n  = 1'b1;
        end else begin
          // The cycle in which pause is pressed still had the relay on, so
          // it still counts down.
          rem_n = remaining - 1'b1;
          if (pause_ev) begin
            state_n = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (!enable) begin
          state_n   = ST_IDLE;
          rem_n     = '0;
          aborted_n = 1'b1;
        end else if (pause_ev) begin
          state_n = ST_PUMP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        rem_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      active_sel <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= rem_n;
      active_sel <= sel_n;
      done       <= done_n;
      aborted    <= aborted_n;
      err        <= err_n;
    end
  end

  assign relay     = (state == ST_PUMP);
  assign busy      = (state != ST_IDLE);
  assign paused    = (state == ST_PAUSE);
  assign state_dbg = state;

endmodule

// File: tb/tb_pump_dose_controller.sv
// -----------------------------------------------------------------------------
// tb_pump_dose_controller
// Directed bench for pump_dose_controller (default build, no debounce).
// Stimulus pushes the expected end-of-dose event {kind, sel, relay-high
// cycles} into exp_q; the monitor pops and compares on every done/aborted/err
// pulse. The stimulus thread also checks point values along the way.
// -----------------------------------------------------------------------------
module tb_pump_dose_controller;
  import pump_pkg::*;

  localparam int N_PRESET = 4;
  localparam int CNT_W    = 32;
  localparam int SEL_W    = 2;
  localparam int EW       = 20;

  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_ABORT = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  logic                      clk;
  logic                      rst_n;
  logic [1:0]                mode;
  logic [N_PRESET-1:0]       btn;
  logic                      btn_pause;
  logic                      estop;
  logic [N_PRESET*CNT_W-1:0] cfg_ticks;
  logic                      relay;
  logic                      busy;
  logic                      paused;
  logic [SEL_W-1:0]          active_sel;
  logic [CNT_W-1:0]          remaining;
  logic                      done;
  logic                      aborted;
  logic                      err;
  state_t                    state_dbg;

  logic [EW-1:0] exp_q[$];
  int vectors;
  int miscompares;
  int relay_cnt;

  pump_dose_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .btn        (btn),
    .btn_pause  (btn_pause),
    .estop      (estop),
    .cfg_ticks  (cfg_ticks),
    .relay      (relay),
    .busy       (busy),
    .paused     (paused),
    .active_sel (active_sel),
    .remaining  (remaining),
    .done       (done),
    .aborted    (aborted),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic [1:0] sel,
                                       input int cnt);
    logic [15:0] c;
    c = cnt[15:0];
    return {kind, sel, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int idx, input logic [CNT_W-1:0] val);
    cfg_ticks[idx*CNT_W +: CNT_W] = val;
  endtask

  // Called at a negedge. Returns at the first cycle that reflects the press:
  // sync takes 2 edges, the FSM registers on the third.
  task automatic press_btn(input logic [N_PRESET-1:0] mask);
    btn = ~mask;
    repeat (3) @(negedge clk);
    btn = '1;
  endtask

  task automatic press_pause();
    btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    btn_pause = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0]    kind;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    if (!rst_n) begin
      relay_cnt = 0;
    end else begin
      if (relay) relay_cnt++;
      if (done || aborted || err) begin
        kind = done ? EV_DONE : (aborted ? EV_ABORT : EV_ERR);
        got  = {kind, active_sel, relay_cnt[15:0]};
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got %h, expected none (t=%0t)", got, $time);
        end else begin
          exp = exp_q.pop_front();
          check("event", 32'(got), 32'(exp));
        end
        relay_cnt = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    relay_cnt   = 0;
    rst_n       = 1'b0;
    mode        = MODE_CODE_MANUAL;
    btn         = '1;
    btn_pause   = 1'b1;
    estop       = 1'b0;
    cfg_ticks   = '0;
    set_cfg(0, 5);
    set_cfg(1, 10);
    set_cfg(2, 20);
    set_cfg(3, 50);

    repeat (3) @(negedge clk);
    check("rst_relay", 32'(relay), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_paused", 32'(paused), 0);
    check("rst_sel", 32'(active_sel), 0);
    check("rst_remaining", remaining, 0);
    check("rst_pulses", {29'd0, done, aborted, err}, 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic 5-tick dose
    exp_q.push_back(ev(EV_DONE, 2'd0, 5));
    press_btn(4'b0001);
    check("t1_relay", 32'(relay), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_rem5", remaining, 5);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("t1_rem", remaining, 32'(5 - i));
    end
    @(negedge clk);
    check("t1_end_relay", 32'(relay), 0);
    check("t1_end_rem", remaining, 0);
    check("t1_end_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // 2: simultaneous presses, lowest wins; mid-dose press ignored
    exp_q.push_back(ev(EV_DONE, 2'd1, 10));
    press_btn(4'b0110);
    check("t2_sel", 32'(active_sel), 1);
    check("t2_rem", remaining, 10);
    press_btn(4'b1000);
    check("t2_sel_hold", 32'(active_sel), 1);
    check("t2_rem_7", remaining, 7);
    wait_idle("t2_idle", 50);
    repeat (3) @(negedge clk);

    // 3: pause after 40 pump cycles, hold 500, resume
    set_cfg(0, 100);
    exp_q.push_back(ev(EV_DONE, 2'd0, 100));
    press_btn(4'b0001);
    check("t3_rem100", remaining, 100);
    set_cfg(0, 3);   // sampled at start, must not affect the running dose
    repeat (37) @(negedge clk);
    press_pause();
    check("t3_paused", 32'(paused), 1);
    check("t3_relay_off", 32'(relay), 0);
    check("t3_frozen", remaining, 60);
    repeat (500) @(negedge clk);
    check("t3_frozen_500", remaining, 60);
    check("t3_still_paused", 32'(state_dbg), 32'(ST_PAUSE));
    press_pause();
    check("t3_resumed", 32'(relay), 1);
    check("t3_resume_rem", remaining, 60);
    wait_idle("t3_idle", 100);
    set_cfg(0, 100);
    repeat (3) @(negedge clk);

    // 4: estop at pump cycle 30, presses ignored while estop held
    exp_q.push_back(ev(EV_ABORT, 2'd0, 30));
    press_btn(4'b0001);
    repeat (29) @(negedge clk);
    check("t4_rem71", remaining, 71);
    estop = 1'b1;
    @(negedge clk);
    check("t4_relay", 32'(relay), 0);
    check("t4_rem", remaining, 0);
    check("t4_busy", 32'(busy), 0);
    press_btn(4'b0001);
    check("t4_ignored0", 32'(busy), 0);
    set_cfg(2, 0);
    press_btn(4'b0100);   // zero preset under estop: no err either
    check("t4_ignored2", 32'(busy), 0);
    estop = 1'b0;
    repeat (3) @(negedge clk);

    // 5: zero preset -> err, stays idle; pause in idle ignored
    exp_q.push_back(ev(EV_ERR, 2'd0, 0));
    press_btn(4'b0100);
    check("t5_relay", 32'(relay), 0);
    check("t5_busy", 32'(busy), 0);
    set_cfg(2, 20);
    press_pause();
    check("t5_pause_idle", 32'(paused), 0);
    check("t5_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (3) @(negedge clk);

    // 6a: reset mid-dose clears everything
    press_btn(4'b0010);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_relay", 32'(relay), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_sel", 32'(active_sel), 0);
    check("t6_rst_rem", remaining, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 6b: mode change while paused -> aborted
    exp_q.push_back(ev(EV_ABORT, 2'd3, 5));
    press_btn(4'b1000);
    repeat (2) @(negedge clk);
    press_pause();
    check("t6_paused", 32'(paused), 1);
    check("t6_frozen", remaining, 45);
    mode = MODE_CODE_AUTO;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_paused_clr", 32'(paused), 0);
    check("t6_rem", remaining, 0);
    check("t6_sel_hold", 32'(active_sel), 3);
    mode = MODE_CODE_MANUAL;

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
